// File: rtl/wb_stream_master.sv
// -----------------------------------------------------------------------------
// wb_stream_master
//
// Byte-stream command engine acting as a Wishbone master. Commands arrive on a
// valid/ready byte stream, are turned into single Wishbone transfers with an
// auto-incrementing address, and status / read data leave on a second
// valid/ready byte stream.
//
//   Write : 0x57 ADDR_HI ADDR_LO LEN D0 .. D(N-1)   -> status 0x4B
//   Read  : 0x52 ADDR_HI ADDR_LO LEN                -> N data bytes
//   N = LEN, LEN = 0 means 256. Unknown opcode -> 0x3F. Bus timeout -> 0x54.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_data_i     command byte stream in
//   in_ready_o               command byte accepted when valid && ready
//   out_valid_o/out_data_o   response byte stream out
//   out_ready_i              response byte consumed when valid && ready
//   cyc_o, stb_o, we_o       Wishbone cycle / strobe / write enable
//   adr_o, dat_o             Wishbone address / write data
//   dat_i, ack_i             Wishbone read data / acknowledge
//   busy_o                   high whenever the engine is not idle
// -----------------------------------------------------------------------------
module wb_stream_master #(
   parameter int unsigned WB_ADDR_WIDTH  = 9,
   parameter int unsigned WB_DATA_WIDTH  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     in_valid_i,
   input  logic [7:0]               in_data_i,
   output logic                     in_ready_o,
   output logic                     out_valid_o,
   output logic [7:0]               out_data_o,
   input  logic                     out_ready_i,
   output logic                     cyc_o,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [WB_ADDR_WIDTH-1:0] adr_o,
   output logic [7:0]               dat_o,
   input  logic [7:0]               dat_i,
   input  logic                     ack_i,
   output logic                     busy_o
);

   // Elaboration-time parameter checks
   if (WB_DATA_WIDTH != 8) begin : g_bad_data_width
      $error("wb_stream_master: WB_DATA_WIDTH must be 8");
   end
   if (WB_ADDR_WIDTH < 1 || WB_ADDR_WIDTH > 16) begin : g_bad_addr_width
      $error("wb_stream_master: WB_ADDR_WIDTH must be 1..16");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("wb_stream_master: TIMEOUT_CYCLES must be >= 2");
   end

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [7:0] OP_WRITE   = 8'h57;
   localparam logic [7:0] OP_READ    = 8'h52;
   localparam logic [7:0] RSP_OK     = 8'h4B;
   localparam logic [7:0] RSP_BADOP  = 8'h3F;
   localparam logic [7:0] RSP_TMO    = 8'h54;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_LEN,
      S_WR_DATA,
      S_WR_BUS,
      S_RD_BUS,
      S_RD_OUT,
      S_RESP,
      S_DRAIN
   } state_e;

   state_e                   state_q, state_d;
   logic                     is_wr_q, is_wr_d;
   logic [7:0]               hi_q,    hi_d;
   logic [WB_ADDR_WIDTH-1:0] adr_q,   adr_d;
   logic [8:0]               cnt_q,   cnt_d;    // transfers still to complete
   logic [7:0]               dat_q,   dat_d;
   logic [7:0]               odat_q,  odat_d;
   logic                     ovld_q,  ovld_d;
   logic [TMO_W-1:0]         tmo_q,   tmo_d;

   logic                     in_fire;
   logic                     out_fire;
   logic                     last_xfer;
   logic                     tmo_hit;
   logic [15:0]              addr_full;
   logic [WB_ADDR_WIDTH-1:0] adr_inc;

   // ready is gated by rst_ni so nothing is accepted while reset is held
   assign in_ready_o = rst_ni && (state_q inside {S_IDLE, S_ADDR_HI, S_ADDR_LO,
                                                  S_LEN, S_WR_DATA, S_DRAIN});
   assign in_fire    = in_valid_i && in_ready_o;
   assign out_fire   = ovld_q && out_ready_i;
   assign last_xfer  = (cnt_q == 9'd1);
   assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign addr_full  = {hi_q, in_data_i};
   assign adr_inc    = adr_q + WB_ADDR_WIDTH'(1);

   // Strobe is a pure state decode, so the asynchronous reset drops it at once
   assign stb_o       = (state_q == S_WR_BUS) || (state_q == S_RD_BUS);
   assign cyc_o       = stb_o;
   assign we_o        = (state_q == S_WR_BUS);
   assign adr_o       = adr_q;
   assign dat_o       = dat_q;
   assign out_valid_o = ovld_q;
   assign out_data_o  = odat_q;
   assign busy_o      = (state_q != S_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         is_wr_q <= 1'b0;
         hi_q    <= '0;
         adr_q   <= '0;
         cnt_q   <= '0;
         dat_q   <= '0;
         odat_q  <= '0;
         ovld_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         hi_q    <= hi_d;
         adr_q   <= adr_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
         odat_q  <= odat_d;
         ovld_q  <= ovld_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      hi_d    = hi_q;
      adr_d   = adr_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;
      odat_d  = odat_q;
      ovld_d  = ovld_q;
      tmo_d   = '0;   // timeout counter only survives while strobing

      unique case (state_q)
         S_IDLE: begin
            if (in_fire) begin
               if (in_data_i == OP_WRITE || in_data_i == OP_READ) begin
                  is_wr_d = (in_data_i == OP_WRITE);
                  state_d = S_ADDR_HI;
               end else begin
                  odat_d  = RSP_BADOP;
                  ovld_d  = 1'b1;
                  state_d = S_RESP;
               end
            end
         end

         S_ADDR_HI: begin
            if (in_fire) begin
               hi_d    = in_data_i;
               state_d = S_ADDR_LO;
            end
         end

         S_ADDR_LO: begin
            if (in_fire) begin
               adr_d   = addr_full[WB_ADDR_WIDTH-1:0];
               state_d = S_LEN;
            end
         end

         S_LEN: begin
            if (in_fire) begin
               cnt_d   = (in_data_i == 8'h00) ? 9'd256 : {1'b0, in_data_i};
               state_d = is_wr_q ? S_WR_DATA : S_RD_BUS;
            end
         end

         S_WR_DATA: begin
            if (in_fire) begin
               dat_d   = in_data_i;
               state_d = S_WR_BUS;
            end
         end

         S_WR_BUS: begin
            if (ack_i) begin
               adr_d = adr_inc;
               cnt_d = cnt_q - 9'd1;
               if (last_xfer) begin
                  odat_d  = RSP_OK;
                  ovld_d  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WR_DATA;
               end
            end else if (tmo_hit) begin
               // The byte on the bus is abandoned; the rest are still owed
               // by the sender and must be swallowed before reporting.
               cnt_d = cnt_q - 9'd1;
               if (last_xfer) begin
                  odat_d  = RSP_TMO;
                  ovld_d  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_DRAIN;
               end
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_RD_BUS: begin
            if (ack_i) begin
               odat_d  = dat_i;
               ovld_d  = 1'b1;
               state_d = S_RD_OUT;
            end else if (tmo_hit) begin
               odat_d  = RSP_TMO;
               ovld_d  = 1'b1;
               state_d = S_RESP;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_RD_OUT: begin
            // Next read waits for this byte to leave, so backpressure never
            // drops or reorders data.
            if (out_fire) begin
               ovld_d  = 1'b0;
               adr_d   = adr_inc;
               cnt_d   = cnt_q - 9'd1;
               state_d = last_xfer ? S_IDLE : S_RD_BUS;
            end
         end

         S_RESP: begin
            if (out_fire) begin
               ovld_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         S_DRAIN: begin
            if (in_fire) begin
               cnt_d = cnt_q - 9'd1;
               if (last_xfer) begin
                  odat_d  = RSP_TMO;
                  ovld_d  = 1'b1;
                  state_d = S_RESP;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_stream_master.sv
// -----------------------------------------------------------------------------
// tb_wb_stream_master
//
// Drives command byte streams into wb_stream_master, attaches a RAM slave that
// acks one cycle after strobe (ack can be disabled), and compares bus
// transfers and response bytes against a command-level model.
// -----------------------------------------------------------------------------
module tb_wb_stream_master;

   localparam int AW  = 9;
   localparam int TMO = 16;

   typedef logic [7:0] byte_q_t [$];
   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [7:0]    dat;
   } xfer_t;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          in_valid_i = 1'b0;
   logic [7:0]    in_data_i = 8'h00;
   logic          in_ready_o;
   logic          out_valid_o;
   logic [7:0]    out_data_o;
   logic          out_ready_i = 1'b1;
   logic          cyc_o;
   logic          stb_o;
   logic          we_o;
   logic [AW-1:0] adr_o;
   logic [7:0]    dat_o;
   logic [7:0]    dat_i;
   logic          ack_i = 1'b0;
   logic          busy_o;

   always #5 clk_i = ~clk_i;

   wb_stream_master #(
      .WB_ADDR_WIDTH (AW),
      .WB_DATA_WIDTH (8),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid_i),
      .in_data_i  (in_data_i),
      .in_ready_o (in_ready_o),
      .out_valid_o(out_valid_o),
      .out_data_o (out_data_o),
      .out_ready_i(out_ready_i),
      .cyc_o      (cyc_o),
      .stb_o      (stb_o),
      .we_o       (we_o),
      .adr_o      (adr_o),
      .dat_o      (dat_o),
      .dat_i      (dat_i),
      .ack_i      (ack_i),
      .busy_o     (busy_o)
   );

   // ---------------- RAM slave: ack one cycle after strobe ----------------
   logic [7:0] ram [0:(1<<AW)-1];
   logic       ack_en  = 1'b1;
   logic       ram_clr = 1'b1;

   always @(posedge clk_i) begin
      if (ram_clr) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= 8'h00;
      end else if (stb_o && ack_i && we_o) begin
         ram[adr_o] <= dat_o;
      end
      ack_i <= stb_o && !ack_i && ack_en;
   end
   assign dat_i = ram[adr_o];

   // ---------------- scoreboard state ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   xfer_t      exp_bus [$];
   logic [7:0] exp_out [$];
   logic [7:0] got     [$];
   logic [7:0] mdl_mem [0:(1<<AW)-1];
   int         exp_stb_len = 2;
   int         stb_rises   = 0;
   int         run_len     = 0;
   logic [AW+8:0] run_sig;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         run_len = 0;
      end else begin
         chk("cyc_eq_stb", 32'(cyc_o), 32'(stb_o));
         chk("no_stb_while_out_pending", 32'(stb_o && out_valid_o), 32'd0);
         if (stb_o) begin
            if (run_len == 0) begin
               stb_rises++;
               run_sig = {adr_o, we_o, dat_o};
            end else begin
               chk("bus_stable", 32'({adr_o, we_o, dat_o}), 32'(run_sig));
            end
            run_len++;
            if (ack_i) begin
               if (exp_bus.size() == 0) begin
                  chk("bus_unexpected_xfer", 32'(adr_o), 32'hFFFF_FFFF);
               end else begin
                  xfer_t e;
                  e = exp_bus.pop_front();
                  chk("bus_we", 32'(we_o), 32'(e.we));
                  chk("bus_adr", 32'(adr_o), 32'(e.adr));
                  if (e.we) chk("bus_dat", 32'(dat_o), 32'(e.dat));
               end
            end
         end else if (run_len != 0) begin
            chk("stb_high_cycles", 32'(run_len), 32'(exp_stb_len));
            run_len = 0;
         end
         if (out_valid_o && out_ready_i) begin
            got.push_back(out_data_o);
            if (exp_out.size() == 0) begin
               chk("out_unexpected_byte", 32'(out_data_o), 32'hFFFF_FFFF);
            end else begin
               chk("out_byte", 32'(out_data_o), 32'(exp_out.pop_front()));
            end
         end
      end
   end

   // ---------------- command-level model ----------------
   task automatic model_cmd(input byte_q_t c);
      logic [AW-1:0] a;
      int            n;
      xfer_t         x;
      if (c[0] != 8'h57 && c[0] != 8'h52) begin
         exp_out.push_back(8'h3F);
         return;
      end
      a = AW'({c[1], c[2]});
      n = (c[3] == 8'h00) ? 256 : int'(c[3]);
      for (int i = 0; i < n; i++) begin
         x.adr = a + AW'(i);
         x.we  = (c[0] == 8'h57);
         x.dat = x.we ? c[4+i] : 8'h00;
         exp_bus.push_back(x);
         if (x.we) mdl_mem[x.adr] = c[4+i];
         else      exp_out.push_back(mdl_mem[x.adr]);
      end
      if (c[0] == 8'h57) exp_out.push_back(8'h4B);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid_i = 1'b1;
      in_data_i  = b;
      @(negedge clk_i);
      while (!in_ready_o && n < 5000) begin
         @(negedge clk_i);
         n++;
      end
      chk("in_ready_wait", 32'(in_ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk_i);
      while ((busy_o || exp_out.size() != 0 || exp_bus.size() != 0) && n < 20000) begin
         @(negedge clk_i);
         n++;
      end
      chk("idle_reached", 32'(busy_o || exp_out.size() != 0 || exp_bus.size() != 0), 32'd0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_cmd(input byte_q_t c);
      model_cmd(c);
      got.delete();
      foreach (c[i]) send_byte(c[i]);
      wait_idle();
   endtask

   task automatic chk_got(input string nm, input byte_q_t e);
      int bad = 0;
      chk({nm, "_len"}, 32'(got.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < got.size(); i++)
         if (got[i] !== e[i]) bad++;
      chk({nm, "_mismatches"}, 32'(bad), 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      byte_q_t c;
      byte_q_t e;
      int      r0;
      int      n;

      for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = 8'h00;

      // reset state
      repeat (3) @(negedge clk_i);
      chk("rst_stb", 32'(stb_o), 32'd0);
      chk("rst_cyc", 32'(cyc_o), 32'd0);
      chk("rst_we", 32'(we_o), 32'd0);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_adr_dat_out", 32'({adr_o, dat_o, out_data_o}), 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni  = 1'b1;
      ram_clr = 1'b0;
      @(posedge clk_i);
      #1;
      chk("idle_in_ready", 32'(in_ready_o), 32'd1);

      // T1: write three bytes at 0x010, read them back
      r0 = stb_rises;
      c = '{8'h57, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
      run_cmd(c);
      chk("t1_strobes", 32'(stb_rises - r0), 32'd3);
      e = '{8'h4B};
      chk_got("t1_wr_resp", e);
      chk("t1_ram", 32'({ram[9'h010], ram[9'h011], ram[9'h012]}), 32'hAABBCC);
      c = '{8'h52, 8'h00, 8'h10, 8'h03};
      run_cmd(c);
      e = '{8'hAA, 8'hBB, 8'hCC};
      chk_got("t1_rd", e);

      // T2: address wrap 0x1FF -> 0x000
      c = '{8'h57, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22};
      run_cmd(c);
      chk("t2_ram_wrap", 32'({ram[9'h1FF], ram[9'h000]}), 32'h1122);
      c = '{8'h52, 8'h01, 8'hFF, 8'h02};
      run_cmd(c);
      e = '{8'h11, 8'h22};
      chk_got("t2_rd", e);

      // T4: unknown opcode, then a read still works
      c = '{8'h00};
      run_cmd(c);
      e = '{8'h3F};
      chk_got("t4_badop", e);
      chk("t4_busy_low", 32'(busy_o), 32'd0);
      c = '{8'h52, 8'h00, 8'h10, 8'h01};
      run_cmd(c);
      e = '{8'hAA};
      chk_got("t4_rd", e);

      // T3: LEN=0 means 256 transfers
      r0 = stb_rises;
      c = '{8'h57, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 256; i++) c.push_back(8'(i));
      run_cmd(c);
      chk("t3_strobes", 32'(stb_rises - r0), 32'd256);
      e = '{8'h4B};
      chk_got("t3_wr_resp", e);
      c = '{8'h52, 8'h00, 8'h00, 8'h00};
      run_cmd(c);
      e = {};
      for (int i = 0; i < 256; i++) e.push_back(8'(i));
      chk_got("t3_rd", e);

      // T5: slave never acks -> timeout, second byte drained
      ack_en      = 1'b0;
      exp_stb_len = TMO;
      r0 = stb_rises;
      got.delete();
      exp_out.push_back(8'h54);
      c = '{8'h57, 8'h00, 8'h00, 8'h02, 8'h55, 8'h66};
      foreach (c[i]) send_byte(c[i]);
      wait_idle();
      repeat (30) @(posedge clk_i);
      #1;
      chk("t5_strobes", 32'(stb_rises - r0), 32'd1);
      e = '{8'h54};
      chk_got("t5_resp", e);
      chk("t5_ram_untouched", 32'({ram[9'h000], ram[9'h001]}), 32'h0001);
      ack_en      = 1'b1;
      exp_stb_len = 2;

      // T6: backpressure then reset in the middle of a read
      out_ready_i = 1'b0;
      got.delete();
      c = '{8'h52, 8'h00, 8'h10, 8'h04};
      model_cmd(c);
      r0 = stb_rises;
      foreach (c[i]) send_byte(c[i]);
      repeat (10) @(posedge clk_i);
      #1;
      chk("t6_out_pending", 32'(out_valid_o), 32'd1);
      chk("t6_single_strobe", 32'(stb_rises - r0), 32'd1);
      out_ready_i = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!stb_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("t6_second_strobe", 32'(stb_o), 32'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_stb", 32'(stb_o), 32'd0);
      chk("t6_rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("t6_rst_in_ready", 32'(in_ready_o), 32'd0);
      exp_bus.delete();
      exp_out.delete();
      e = '{8'h10};
      chk_got("t6_before_rst", e);
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      chk("t6_busy_after_rst", 32'(busy_o), 32'd0);
      c = '{8'h52, 8'h00, 8'h10, 8'h01};
      run_cmd(c);
      e = '{8'h10};
      chk_got("t6_after_rst", e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stream_master.md
Name: wb_stream_master

Overview:
Byte-stream command engine that acts as the Wishbone master in front of a Wishbone RAM/peripheral slave.
It parses write and read commands from a valid/ready byte stream and issues single Wishbone transfers with an auto-incrementing address.
It returns status and read data on a second valid/ready byte stream.
A UART or USB byte pipe typically sits upstream and the RAM sits downstream.

Parameters:
WB_ADDR_WIDTH, 9, slave address width (1..16); command address bits above this width are discarded.
WB_DATA_WIDTH, 8, data width; only 8 is supported, and elaboration fails on any other value.
TIMEOUT_CYCLES, 64, maximum cycles stb_o may stay high without ack_i before the transfer is aborted (>=2).

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  command byte valid
in_data_i  input  8  command byte
in_ready_o  output  1  command byte accepted on edge when in_valid_i&&in_ready_o
out_valid_o  output  1  response byte valid
out_data_o  output  8  response byte
out_ready_i  input  1  response byte consumed on edge when out_valid_o&&out_ready_i
cyc_o  output  1  Wishbone cycle, equal to stb_o
stb_o  output  1  Wishbone strobe
we_o  output  1  Wishbone write enable
adr_o  output  WB_ADDR_WIDTH  Wishbone address
dat_o  output  8  Wishbone write data
dat_i  input  8  Wishbone read data
ack_i  input  1  Wishbone acknowledge
busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; stb_o, cyc_o, we_o, out_valid_o and busy_o are 0; adr_o, dat_o and out_data_o are 0; the address and length registers are cleared; in_ready_o is forced to 0 while rst_ni is low.
- Command formats:
  - Write: 0x57, ADDR_HI, ADDR_LO, LEN, then N data bytes.
  - Read: 0x52, ADDR_HI, ADDR_LO, LEN.
  - N = LEN, except LEN=0 means N=256.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, WR_DATA, WR_BUS, RD_BUS, RD_OUT, RESP, DRAIN.
- in_ready_o is high only in IDLE, ADDR_HI, ADDR_LO, LEN, WR_DATA and DRAIN. Every other state advances only on its own event.
- IDLE:
  - byte 0x57 or 0x52 -> ADDR_HI.
  - any other byte -> RESP with response byte 0x3F.
- ADDR_HI -> ADDR_LO -> LEN: address = {HI,LO} truncated to WB_ADDR_WIDTH.
- LEN:
  - write command -> WR_DATA.
  - read command -> RD_BUS.
- WR_DATA: an accepted byte loads dat_o, then -> WR_BUS.
- WR_BUS: stb_o=cyc_o=we_o=1.
  - On the first edge with ack_i high: stb_o drops, address increments modulo 2^WB_ADDR_WIDTH, and the remaining count decrements.
  - Then -> WR_DATA, or -> RESP with 0x4B once N transfers have completed.
- RD_BUS: stb_o=cyc_o=1, we_o=0.
  - On the ack edge: dat_i is latched into out_data_o, out_valid_o=1, stb_o drops, -> RD_OUT.
- RD_OUT: holds until out_ready_i. Then increments the address and -> RD_BUS, or -> IDLE after N bytes. Read commands emit no status byte.
- RESP: out_valid_o=1 with the status byte; -> IDLE on acceptance.
- Bus rules:
  - ack_i is ignored whenever stb_o=0. A stray ack in the cycle after stb drops must not complete anything.
  - stb_o is low for at least one full cycle between consecutive transfers.
  - adr_o, we_o and dat_o are stable while stb_o is high.
  - Against a slave that acks one cycle after strobe, each transfer occupies stb_o for exactly 2 cycles.
- Timeout: a counter runs while stb_o=1 and clears when stb_o falls.
  - If TIMEOUT_CYCLES cycles elapse with no ack, stb_o drops on that edge.
  - Write: -> DRAIN, which consumes and discards the remaining unsent data bytes, then -> RESP 0x54.
  - Read: -> RESP 0x54 immediately; bytes already emitted stand.
- Output backpressure: the next read transfer is not issued until the previous byte is accepted, so read data is never lost or reordered.
- Reset mid-operation: stb_o drops asynchronously and any partial command is discarded. After release, the engine expects a fresh opcode.

Test Plan:
- Attach a RAM that acks one cycle after strobe, WB_ADDR_WIDTH=9, send 57 00 10 03 AA BB CC -> three writes at adr 0x010/0x011/0x012, each with stb high 2 cycles; out 4B. Then send 52 00 10 03 -> out AA BB CC.
- Send 57 01 FF 02 11 22 -> writes to 0x1FF then 0x000; a following read 52 01 FF 02 returns 11 22.
- Write with LEN=00 and 256 bytes 0x00..0xFF from 0x000 -> exactly 256 strobes, single 4B. Read back with LEN=00 -> 256 bytes in order.
- Send byte 0x00 -> out 3F, busy_o returns low. A following 52 00 10 01 still returns AA.
- Hold ack_i=0, TIMEOUT_CYCLES=16, send 57 00 00 02 55 66 -> stb_o high exactly 16 cycles, byte 66 drained, out 54, no further strobe.
- During a 4-byte read, hold out_ready_i low 10 cycles, then pulse rst_ni low mid-RD_BUS -> no strobe while out_valid_o is pending; on reset stb_o and out_valid_o fall to 0 immediately; a next command completes normally.
